// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//   Shares one UART transmit line among N_REQ byte sources. A round-robin
//   arbiter picks the next requester and an 8N1-style serializer, paced by the
//   one-cycle bit_tick pulse from the baud generator, sends the frame:
//   start bit, DATA_W data bits LSB first, optional even parity, stop bit.
//   Back-to-back frames follow each other with no extra idle bit.
//
// Optional feature macro:
//   UART_TX_PARITY_EN  - when defined, an even-parity bit follows the data bits.
//
// Parameters:
//   N_REQ   number of requesters (>= 1)
//   DATA_W  bits per frame (1..9)
//   IDW     width of grant_id (derived)
//
// Ports:
//   CLK        in   system clock
//   rst        in   synchronous, active-high reset
//   bit_tick   in   one-cycle pulse per bit period
//   req_valid  in   [N_REQ]         requester i has a byte pending
//   req_data   in   [N_REQ*DATA_W]  byte of requester i at [i*DATA_W +: DATA_W]
//   req_ready  out  [N_REQ]         one-cycle accept pulse, one-hot or zero
//   grant_id   out  [IDW]           index of the last accepted requester
//   busy       out                  frame in progress (accept .. back to IDLE)
//   tx         out                  serial line, idle high, registered
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter  int N_REQ  = 4,
  parameter  int DATA_W = 8,
  localparam int IDW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                    CLK,
  input  logic                    rst,
  input  logic                    bit_tick,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  output logic [IDW-1:0]          grant_id,
  output logic                    busy,
  output logic                    tx
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WAIT   = 3'd1,
    ST_START  = 3'd2,
    ST_DATA   = 3'd3,
`ifdef UART_TX_PARITY_EN
    ST_PARITY = 3'd4,
`endif
    ST_STOP   = 3'd5
  } state_t;

`ifdef UART_TX_PARITY_EN
  // Even parity over one data word: the bit that makes the total count of ones even.
  function automatic logic even_parity_f(input logic [DATA_W-1:0] d);
    even_parity_f = ^d;
  endfunction
`endif

  // Registered state
  state_t              state_r;
  logic                tx_r;
  logic                busy_r;
  logic [DATA_W-1:0]   shift_r;
  logic [CNT_W-1:0]    bitcnt_r;
  logic [IDW-1:0]      rr_ptr_r;
  logic [IDW-1:0]      grant_id_r;
`ifdef UART_TX_PARITY_EN
  logic                parity_r;
  logic                parity_nx_s;
`endif

  // Next-state values
  state_t              state_nx_s;
  logic                tx_nx_s;
  logic                busy_nx_s;
  logic [DATA_W-1:0]   shift_nx_s;
  logic [CNT_W-1:0]    bitcnt_nx_s;
  logic [IDW-1:0]      rr_ptr_nx_s;
  logic [IDW-1:0]      grant_id_nx_s;

  // Arbitration helpers
  logic                any_valid_s;
  logic [IDW-1:0]      grant_idx_s;
  logic [DATA_W-1:0]   sel_data_s;
  logic                accept_s;
  logic [N_REQ-1:0]    ready_s;

  assign any_valid_s = |req_valid;

  // Round-robin pick: scanning from the farthest candidate back to rr_ptr+1
  // lets the nearest valid requester after rr_ptr win the last assignment.
  always_comb begin
    grant_idx_s = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      grant_idx_s = req_valid[IDW'((int'(rr_ptr_r) + k) % N_REQ)]
                  ? IDW'((int'(rr_ptr_r) + k) % N_REQ)
                  : grant_idx_s;
    end
  end

  // Data mux for the selected requester.
  always_comb begin
    sel_data_s = '0;
    for (int i = 0; i < N_REQ; i++) begin
      sel_data_s = (grant_idx_s == IDW'(i)) ? req_data[i*DATA_W +: DATA_W] : sel_data_s;
    end
  end

  // Frame sequencer: next-state, next-output and accept decisions.
  always_comb begin
    state_nx_s    = state_r;
    tx_nx_s       = tx_r;
    busy_nx_s     = busy_r;
    shift_nx_s    = shift_r;
    bitcnt_nx_s   = bitcnt_r;
    rr_ptr_nx_s   = rr_ptr_r;
    grant_id_nx_s = grant_id_r;
    accept_s      = 1'b0;
    ready_s       = '0;
`ifdef UART_TX_PARITY_EN
    parity_nx_s   = parity_r;
`endif

    case (state_r)
      ST_IDLE: begin
        // A tick coinciding with the accept is ignored; WAIT needs a fresh one.
        if (any_valid_s) begin
          accept_s   = 1'b1;
          state_nx_s = ST_WAIT;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end

      ST_WAIT: begin
        if (bit_tick) begin
          tx_nx_s    = 1'b0;
          state_nx_s = ST_START;
        end else begin
          state_nx_s = ST_WAIT;
        end
      end

      ST_START: begin
        if (bit_tick) begin
          tx_nx_s     = shift_r[0];
          shift_nx_s  = shift_r >> 1'b1;
          bitcnt_nx_s = '0;
          state_nx_s  = ST_DATA;
        end else begin
          state_nx_s  = ST_START;
        end
      end

      ST_DATA: begin
        if (bit_tick) begin
          if (bitcnt_r == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            tx_nx_s    = parity_r;
            state_nx_s = ST_PARITY;
`else
            tx_nx_s    = 1'b1;
            state_nx_s = ST_STOP;
`endif
          end else begin
            // shift_r already holds the next data bit at position 0.
            tx_nx_s     = shift_r[0];
            shift_nx_s  = shift_r >> 1'b1;
            bitcnt_nx_s = bitcnt_r + CNT_W'(1);
            state_nx_s  = ST_DATA;
          end
        end else begin
          state_nx_s = ST_DATA;
        end
      end

`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_tick) begin
          tx_nx_s    = 1'b1;
          state_nx_s = ST_STOP;
        end else begin
          state_nx_s = ST_PARITY;
        end
      end
`endif

      ST_STOP: begin
        if (bit_tick) begin
          if (any_valid_s) begin
            // Back-to-back: the next start bit begins right at the stop-ending tick.
            accept_s   = 1'b1;
            tx_nx_s    = 1'b0;
            state_nx_s = ST_START;
          end else begin
            busy_nx_s  = 1'b0;
            state_nx_s = ST_IDLE;
          end
        end else begin
          state_nx_s = ST_STOP;
        end
      end

      default: begin
        tx_nx_s    = 1'b1;
        busy_nx_s  = 1'b0;
        state_nx_s = ST_IDLE;
      end
    endcase

    if (accept_s) begin
      // Ready is the live handshake for this cycle; suppress it under reset.
      ready_s[grant_idx_s] = ~rst;
      shift_nx_s           = sel_data_s;
      grant_id_nx_s        = grant_idx_s;
      rr_ptr_nx_s          = grant_idx_s;
      busy_nx_s            = 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_nx_s          = even_parity_f(sel_data_s);
`endif
    end else begin
      ready_s = '0;
    end
  end

  // State and datapath registers with synchronous reset; reset aborts any frame.
  always_ff @(posedge CLK) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      tx_r       <= 1'b1;
      busy_r     <= 1'b0;
      shift_r    <= '0;
      bitcnt_r   <= '0;
      rr_ptr_r   <= IDW'(N_REQ - 1);
      grant_id_r <= '0;
`ifdef UART_TX_PARITY_EN
      parity_r   <= 1'b0;
`endif
    end else begin
      state_r    <= state_nx_s;
      tx_r       <= tx_nx_s;
      busy_r     <= busy_nx_s;
      shift_r    <= shift_nx_s;
      bitcnt_r   <= bitcnt_nx_s;
      rr_ptr_r   <= rr_ptr_nx_s;
      grant_id_r <= grant_id_nx_s;
`ifdef UART_TX_PARITY_EN
      parity_r   <= parity_nx_s;
`endif
    end
  end

  assign req_ready = ready_s;
  assign grant_id  = grant_id_r;
  assign busy      = busy_r;
  assign tx        = tx_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
//   Self-checking bench for uart_tx_arbiter (N_REQ=4, DATA_W=8, bit_tick every
//   16 CLK). A serial-line monitor decodes tx into bytes and compares them to a
//   scoreboard; grant order comes from a round-robin model over requester queues.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

  localparam int N_REQ  = 4;
  localparam int DATA_W = 8;
  localparam int TICK   = 16;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = DATA_W + 3;
`else
  localparam int FRAME_BITS = DATA_W + 2;
`endif
  localparam int FRAME_CLK = FRAME_BITS * TICK;

  logic                    CLK;
  logic                    rst;
  logic                    bit_tick;
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        req_ready;
  logic [1:0]              grant_id;
  logic                    busy;
  logic                    tx;

  uart_tx_arbiter #(.N_REQ(N_REQ), .DATA_W(DATA_W)) dut (
    .CLK      (CLK),
    .rst      (rst),
    .bit_tick (bit_tick),
    .req_valid(req_valid),
    .req_data (req_data),
    .req_ready(req_ready),
    .grant_id (grant_id),
    .busy     (busy),
    .tx       (tx)
  );

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] data;
    int          gnt;
    logic [7:0]  byte_exp;
  } vec_t;

  int         n_vec;
  int         n_bad;
  logic [7:0] exp_q[$];
  time        starts[$];
  logic       mon_en;
  int         tick_cnt;
  int         rr_model;
  logic [7:0] qs[N_REQ][$];

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge CLK);
    #1;
  endtask

  task automatic tick_gen();
    forever begin
      @(negedge CLK);
      tick_cnt = (tick_cnt == TICK - 1) ? 0 : tick_cnt + 1;
      bit_tick = (tick_cnt == TICK - 1);
    end
  endtask

  // Serial receiver: finds a start bit and samples each bit in mid-period.
  task automatic monitor();
    logic [7:0] rx;
    forever begin
      @(posedge CLK);
      #1;
      if (mon_en && (tx === 1'b0)) begin
        starts.push_back($time);
        repeat (TICK / 2) @(posedge CLK);
        #1;
        check("start_bit", tx, 1'b0);
        for (int b = 0; b < DATA_W; b++) begin
          repeat (TICK) @(posedge CLK);
          #1;
          rx[b] = tx;
        end
`ifdef UART_TX_PARITY_EN
        repeat (TICK) @(posedge CLK);
        #1;
        check("parity_bit", tx, ^rx);
`endif
        repeat (TICK) @(posedge CLK);
        #1;
        check("stop_bit", tx, 1'b1);
        check("frame_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) check("rx_byte", rx, exp_q.pop_front());
      end
    end
  endtask

  task automatic wait_ready(input int budget, output logic [3:0] got);
    got = 4'b0;
    for (int i = 0; i < budget; i++) begin
      #1;
      if (req_ready != 4'b0) begin
        got = req_ready;
        break;
      end
      @(negedge CLK);
    end
  endtask

  task automatic wait_idle(input int budget, output time t);
    t = $time;
    for (int i = 0; i < budget; i++) begin
      @(negedge CLK);
      #1;
      t = $time;
      if (!busy) break;
    end
  endtask

  // Drives the requester queues as live sources and checks the grant sequence
  // against round-robin order over whichever queues are non-empty.
  task automatic run_burst(input string nm);
    int order[$];
    int cnt[N_REQ];
    int ptr[N_REQ];
    int rr, total, gi, j;
    logic pend;
    logic [3:0] mask;
    rr = rr_model;
    total = 0;
    for (int i = 0; i < N_REQ; i++) begin
      cnt[i] = qs[i].size();
      ptr[i] = 0;
      total += cnt[i];
    end
    for (int f = 0; f < total; f++) begin
      for (int k = 1; k <= N_REQ; k++) begin
        j = (rr + k) % N_REQ;
        if (cnt[j] > 0) begin
          order.push_back(j);
          exp_q.push_back(qs[j][ptr[j]]);
          ptr[j]++;
          cnt[j]--;
          rr = j;
          break;
        end
      end
    end
    starts.delete();
    gi = 0;
    pend = 1'b0;
    for (int c = 0; c < total * FRAME_CLK + 400; c++) begin
      @(negedge CLK);
      #1;
      if (pend) begin
        check({nm, "_grant_id"}, grant_id, order[gi-1]);
        pend = 1'b0;
      end
      for (int i = 0; i < N_REQ; i++) begin
        req_valid[i] = (qs[i].size() != 0);
        req_data[i*DATA_W +: DATA_W] = (qs[i].size() != 0) ? qs[i][0] : 8'h00;
      end
      #1;
      if (req_ready != 4'b0) begin
        mask = (gi < total) ? (4'b0001 << order[gi]) : 4'b0000;
        check({nm, "_ready"}, req_ready, mask);
        for (int i = 0; i < N_REQ; i++) begin
          if (req_ready[i] && qs[i].size() != 0) void'(qs[i].pop_front());
        end
        if (gi < total) begin
          rr_model = order[gi];
          pend = 1'b1;
        end
        gi++;
      end
      if (gi >= total && !pend && !busy) break;
    end
    req_valid = 4'b0;
    check({nm, "_grants"}, gi, total);
    check({nm, "_frames"}, starts.size(), total);
    for (int k = 1; k < starts.size(); k++) begin
      check({nm, "_spacing"}, int'((starts[k] - starts[k-1]) / 10), FRAME_CLK);
    end
    check({nm, "_sb_empty"}, exp_q.size(), 0);
  endtask

  initial begin
    vec_t       tbl[8];
    logic [3:0] got;
    logic [3:0] mask;
    logic [3:0] seen;
    time        t;
    int         tot;

    n_vec     = 0;
    n_bad     = 0;
    rst       = 1'b1;
    bit_tick  = 1'b0;
    tick_cnt  = 0;
    req_valid = 4'b0;
    req_data  = 32'h0;
    mon_en    = 1'b0;
    rr_model  = N_REQ - 1;

    tbl[0] = '{4'b0001, 32'h0000_0055, 0, 8'h55};
    tbl[1] = '{4'b0101, 32'h00C3_003A, 2, 8'hC3};
    tbl[2] = '{4'b0101, 32'h00E7_0007, 0, 8'h07};
    tbl[3] = '{4'b1000, 32'h0300_0000, 3, 8'h03};
    tbl[4] = '{4'b1111, 32'hD4C3_B2A1, 0, 8'hA1};
    tbl[5] = '{4'b0010, 32'h0000_FF00, 1, 8'hFF};
    tbl[6] = '{4'b0011, 32'h0000_8001, 0, 8'h01};
    tbl[7] = '{4'b1110, 32'h9A8B_4200, 1, 8'h42};

    fork
      monitor();
      tick_gen();
    join_none

    repeat (5) step();
    check("rst_tx", tx, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_ready", req_ready, 4'b0);
    check("rst_grant_id", grant_id, 2'd0);
    rst = 1'b0;
    step();
    mon_en = 1'b1;

    // Single-frame vectors from IDLE; each row's grant depends on the previous one.
    for (int v = 0; v < 8; v++) begin
      step();
      req_valid = tbl[v].valid;
      req_data  = tbl[v].data;
      wait_ready(40, got);
      mask = 4'b0001 << tbl[v].gnt;
      check("tbl_ready", got, mask);
      exp_q.push_back(tbl[v].byte_exp);
      rr_model = tbl[v].gnt;
      step();
      req_valid = 4'b0;
      check("tbl_grant_id", grant_id, tbl[v].gnt);
      check("tbl_busy_set", busy, 1'b1);
      wait_idle(400, t);
      check("tbl_busy_clear", busy, 1'b0);
      check("tbl_start_seen", starts.size() != 0, 1'b1);
      if (starts.size() != 0) check("tbl_frame_cycles", int'((t - starts[$] - 5) / 10), FRAME_CLK);
      check("tbl_tx_idle", tx, 1'b1);
    end

    // Requester 1 arrives mid-frame while requester 2 still has a byte pending.
    step();
    req_valid = 4'b0100;
    req_data  = 32'h003C_0000;
    wait_ready(40, got);
    check("seq4_first", got, 4'b0100);
    exp_q.push_back(8'h3C);
    step();
    req_data[23:16] = 8'h5A;
    check("seq4_no_early_ready", req_ready, 4'b0);
    repeat (50) step();
    req_valid = 4'b0110;
    req_data[15:8] = 8'h11;
    wait_ready(300, got);
    check("seq4_second", got, 4'b0010);
    exp_q.push_back(8'h11);
    step();
    req_valid = 4'b0100;
    wait_ready(300, got);
    check("seq4_third", got, 4'b0100);
    exp_q.push_back(8'h5A);
    rr_model = 2;
    step();
    req_valid = 4'b0;
    wait_idle(400, t);
    check("seq4_idle", busy, 1'b0);

    // A one-cycle valid pulse during a frame is never granted.
    step();
    req_valid = 4'b0001;
    req_data  = 32'h0000_0081;
    wait_ready(40, got);
    check("seq5_first", got, 4'b0001);
    exp_q.push_back(8'h81);
    rr_model = 0;
    step();
    req_valid = 4'b0;
    repeat (40) step();
    req_valid = 4'b1000;
    req_data[31:24] = 8'hEE;
    #1;
    check("seq5_pulse_no_ready", req_ready, 4'b0);
    step();
    req_valid = 4'b0;
    seen = 4'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge CLK);
      #1;
      seen = seen | req_ready;
      if (!busy) break;
    end
    check("seq5_no_ready_after", seen, 4'b0);
    check("seq5_idle", busy, 1'b0);

    // Reset mid-frame, with all requesters valid during reset.
    mon_en = 1'b0;
    step();
    req_valid = 4'b0010;
    req_data  = 32'h0000_9900;
    wait_ready(40, got);
    check("rst_mid_accept", got, 4'b0010);
    step();
    req_valid = 4'b0;
    repeat (50) step();
    req_valid = 4'b1111;
    rst = 1'b1;
    step();
    check("rst_mid_tx", tx, 1'b1);
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_ready", req_ready, 4'b0);
    repeat (4) step();
    check("rst_hold_ready", req_ready, 4'b0);
    req_valid = 4'b0;
    rst = 1'b0;
    rr_model = N_REQ - 1;
    step();
    check("rst_rel_tx", tx, 1'b1);
    check("rst_rel_busy", busy, 1'b0);
    check("rst_rel_grant_id", grant_id, 2'd0);
    repeat (20) step();
    mon_en = 1'b1;

    // All requesters held valid: order 0,1,2,3,0 and contiguous frames.
    for (int i = 0; i < N_REQ; i++) qs[i].push_back(8'(8'hA0 + i));
    qs[0].push_back(8'hA0);
    run_burst("allvalid");

    // Random backlogs at random tick phases.
    for (int b = 0; b < 6; b++) begin
      repeat ($urandom_range(1, 40)) step();
      tot = 0;
      for (int i = 0; i < N_REQ; i++) begin
        repeat ($urandom_range(0, 3)) qs[i].push_back(8'($urandom_range(0, 255)));
        tot += qs[i].size();
      end
      if (tot == 0) qs[$urandom_range(0, N_REQ - 1)].push_back(8'($urandom_range(0, 255)));
      run_burst("rand");
    end

    repeat (20) step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
